// File: rtl/morphle_pkg.sv
// Shared definitions for Morphle Logic row configuration: cell codes,
// loader FSM states and the per-cell code decoder.
package morphle_pkg;

  localparam int unsigned CBITS = 3;

  localparam logic [CBITS-1:0] YC_SPACE = 3'b000;
  localparam logic [CBITS-1:0] YC_PLUS  = 3'b001;
  localparam logic [CBITS-1:0] YC_HBAR  = 3'b010;
  localparam logic [CBITS-1:0] YC_VBAR  = 3'b011;
  localparam logic [CBITS-1:0] YC_ONE   = 3'b100;
  localparam logic [CBITS-1:0] YC_ZERO  = 3'b101;
  localparam logic [CBITS-1:0] YC_X     = 3'b110;
  localparam logic [CBITS-1:0] YC_RSVD  = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_COMMIT
  } yc_state_t;

  typedef struct packed {
    logic empty;
    logic hblock;
    logic hbypass;
    logic hmatch0;
    logic hmatch1;
    logic vblock;
    logic vbypass;
    logic vmatch0;
    logic vmatch1;
  } yc_flags_t;

  // Reserved code falls through to the default and behaves as an empty cell.
  function automatic yc_flags_t ycdecode(input logic [CBITS-1:0] code);
    yc_flags_t f;
    f = '0;
    case (code)
      YC_PLUS: ;
      YC_HBAR: f.vblock = 1'b1;
      YC_VBAR: f.hblock = 1'b1;
      YC_ONE: begin
        f.hmatch1 = 1'b1;
        f.vmatch1 = 1'b1;
      end
      YC_ZERO: begin
        f.hmatch0 = 1'b1;
        f.vmatch0 = 1'b1;
      end
      YC_X: begin
        f.hbypass = 1'b1;
        f.vbypass = 1'b1;
      end
      default: f.empty = 1'b1;
    endcase
    return f;
  endfunction

endpackage

// File: rtl/ycdecode_cell.sv
// Combinational decode of one cell's 3-bit configuration code into its
// nine control flags.
module ycdecode_cell
  import morphle_pkg::*;
(
  input  logic [CBITS-1:0] code,
  output logic             empty,
  output logic             hblock,
  output logic             hbypass,
  output logic             hmatch0,
  output logic             hmatch1,
  output logic             vblock,
  output logic             vbypass,
  output logic             vmatch0,
  output logic             vmatch1
);

  yc_flags_t f;

  always_comb begin
    f       = ycdecode(code);
    empty   = f.empty;
    hblock  = f.hblock;
    hbypass = f.hbypass;
    hmatch0 = f.hmatch0;
    hmatch1 = f.hmatch1;
    vblock  = f.vblock;
    vbypass = f.vbypass;
    vmatch0 = f.vmatch0;
    vmatch1 = f.vmatch1;
  end

endmodule

// File: rtl/ycconfig_row.sv
// Serial configuration loader for a row of N cells: shift chain under a
// start/valid/ready handshake, atomic commit to a shadow, decoded outputs.
module ycconfig_row
  import morphle_pkg::*;
#(
  parameter int unsigned N = 4
) (
  input  logic         confclk,
  input  logic         reset,
  input  logic         cstart,
  input  logic         cvalid,
  input  logic         cbitin,
  output logic         cready,
  output logic         cbitout,
  output logic         cdone,
  output logic [N-1:0] empty,
  output logic [N-1:0] hblock,
  output logic [N-1:0] hbypass,
  output logic [N-1:0] hmatch0,
  output logic [N-1:0] hmatch1,
  output logic [N-1:0] vblock,
  output logic [N-1:0] vbypass,
  output logic [N-1:0] vmatch0,
  output logic [N-1:0] vmatch1
);

  localparam int unsigned W  = CBITS * N;
  localparam int unsigned CW = $clog2(W + 1);

  yc_state_t       state, state_n;
  logic [W-1:0]    sr, cfg;
  logic [CW-1:0]   cnt;
  logic            shift, clr, last;

  assign last    = (cnt == CW'(W - 1));
  assign cbitout = sr[W-1];

  always_comb begin
    state_n = state;
    cready  = 1'b0;
    cdone   = 1'b0;
    shift   = 1'b0;
    clr     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (cstart) begin
          state_n = ST_LOAD;
          clr     = 1'b1;
        end
      end
      ST_LOAD: begin
        cready = 1'b1;
        if (cstart) begin
          clr = 1'b1;
        end else if (cvalid) begin
          shift = 1'b1;
          if (last) state_n = ST_COMMIT;
        end
      end
      ST_COMMIT: begin
        cdone   = 1'b1;
        state_n = ST_IDLE;
      end
      default: state_n = ST_IDLE;
    endcase
  end

  // The shadow captures the post-shift chain on the same edge that enters
  // COMMIT, so the new decode is already visible while cdone is high.
  always_ff @(posedge confclk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
      sr    <= '0;
      cfg   <= '0;
      cnt   <= '0;
    end else begin
      state <= state_n;
      if (clr)
        cnt <= '0;
      else if (shift)
        cnt <= cnt + CW'(1);
      if (shift)
        sr <= {sr[W-2:0], cbitin};
      if (shift && last)
        cfg <= {sr[W-2:0], cbitin};
    end
  end

  for (genvar k = 0; k < N; k++) begin : g_cell
    ycdecode_cell u_cell (
      .code    (cfg[CBITS*k +: CBITS]),
      .empty   (empty[k]),
      .hblock  (hblock[k]),
      .hbypass (hbypass[k]),
      .hmatch0 (hmatch0[k]),
      .hmatch1 (hmatch1[k]),
      .vblock  (vblock[k]),
      .vbypass (vbypass[k]),
      .vmatch0 (vmatch0[k]),
      .vmatch1 (vmatch1[k])
    );
  end

endmodule
